// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter and runs one instruction-memory fetch at a time,
//   handing each fetched word to decode over a valid/ready handshake. A taken
//   branch (pc_write_enabled) redirects the PC and squashes any in-flight or
//   held instruction.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       holds off the start of a new fetch (IDLE only)
//   pc_write_enabled            branch taken: load dest_address into the PC
//   dest_address [ADDR_W]       branch target
//   imem_req / imem_addr        fetch request, held with stable address until ack
//   imem_ack / imem_rdata       memory response and fetched word
//   instr_valid / instr /
//   instr_pc                    live instruction presented to decode
//   instr_ready                 decode accepts instr this cycle
//   fault                       (FETCH_WRAP_TRAP_EN only) wrap trap taken
//
// Build option
//   FETCH_WRAP_TRAP_EN: capturing an instruction at pc = all-ones raises fault
//   and parks the sequencer in HALT until reset. Without it the PC wraps to 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request outstanding; start one next cycle unless stalled
// REQ     | request live at imem_addr = pc, waiting for imem_ack
// DRAIN   | request squashed by a redirect; wait for its ack, drop the data
// DELIVER | instr/instr_pc valid, waiting for instr_ready
// HALT    | wrap trap taken; no fetches, redirects ignored (trap build only)

module fetch_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                INSTR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               pc_write_enabled,
  input  logic [ADDR_W-1:0]  dest_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
`ifdef FETCH_WRAP_TRAP_EN
  output logic               fault,
`endif
  input  logic               instr_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
`ifdef FETCH_WRAP_TRAP_EN
  localparam logic [2:0] S_HALT    = 3'd4;
`endif

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               redirect;
  logic               done_state;

`ifdef FETCH_WRAP_TRAP_EN
  logic fault_q, fault_d;
  // Once the trap is taken the PC is frozen against branches as well.
  assign redirect   = pc_write_enabled & ~fault_q;
  assign done_state = fault_q;
`else
  assign redirect   = pc_write_enabled;
  assign done_state = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
`ifdef FETCH_WRAP_TRAP_EN
    fault_d      = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = dest_address;
        end else if (!stall) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          pc_d = dest_address;
          if (imem_ack) begin
            state_d = S_IDLE;
          end else begin
            // The memory still owes us a response for the old address, so keep
            // presenting it while pc already carries the branch target.
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_ONE;
          state_d    = S_DELIVER;
`ifdef FETCH_WRAP_TRAP_EN
          if (&pc_q) fault_d = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        if (redirect) pc_d = dest_address;
        if (imem_ack) state_d = S_IDLE;
      end
      S_DELIVER: begin
        if (redirect) begin
          pc_d    = dest_address;
          state_d = S_IDLE;
        end else if (instr_ready) begin
`ifdef FETCH_WRAP_TRAP_EN
          state_d = done_state ? S_HALT : S_IDLE;
`else
          state_d = done_state ? S_DELIVER : S_IDLE;
`endif
        end
      end
`ifdef FETCH_WRAP_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      drain_addr_q <= RESET_VECTOR;
      instr_q      <= '0;
      instr_pc_q   <= '0;
`ifdef FETCH_WRAP_TRAP_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
`ifdef FETCH_WRAP_TRAP_EN
      fault_q      <= fault_d;
`endif
    end
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign instr_valid = (state_q == S_DELIVER);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef FETCH_WRAP_TRAP_EN
  assign fault       = fault_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed scenarios for the fetch sequencer followed by a randomized run
//   checked against a transaction-level model of the fetch stream: each new
//   request must target the expected next address, squashed responses must
//   never surface, and every delivered word must match the memory response
//   for its address.

module tb_fetch_sequencer;

  localparam int          ADDR_W  = 16;
  localparam int          INSTR_W = 16;
  localparam logic [15:0] RV      = 16'h0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic               pc_write_enabled;
  logic [ADDR_W-1:0]  dest_address;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
`ifdef FETCH_WRAP_TRAP_EN
  logic               fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_VECTOR(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc_write_enabled(pc_write_enabled), .dest_address(dest_address),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
`ifdef FETCH_WRAP_TRAP_EN
    .fault(fault),
`endif
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cyc, output bit ok, output int cyc, output bit saw_valid);
    cyc = 0;
    saw_valid = 1'b0;
    while (!imem_req && cyc < max_cyc) begin
      tick();
      cyc++;
      if (instr_valid) saw_valid = 1'b1;
    end
    ok = imem_req;
  endtask

  task automatic ack_now(input logic [15:0] data);
    imem_ack = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic redirect_now(input logic [15:0] dest);
    pc_write_enabled = 1'b1;
    dest_address = dest;
    tick();
    pc_write_enabled = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b1; pc_write_enabled = 1'b0; dest_address = '0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, RV, 1'b0, 16'h0, 16'h0})
      $display("FAIL reset_values: got req=%b addr=%h v=%b instr=%h pc=%h required 0/%h/0/0000/0000",
               imem_req, imem_addr, instr_valid, instr, instr_pc, RV);
    if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, RV, 1'b0, 16'h0, 16'h0}) n_fail++;
`ifdef FETCH_WRAP_TRAP_EN
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b required 0", fault); end
`endif
    rst_n = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_after_reset: got req=%b v=%b required 0/0", imem_req, instr_valid);
    end
  endtask

  task automatic test_basic;
    bit ok; int cyc; bit sv;
    instr_ready = 1'b1;
    stall = 1'b0;
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0000 || cyc != 1) begin
      n_fail++;
      $display("FAIL basic_req0: got ok=%b addr=%h lat=%0d required 1/0000/1", ok, imem_addr, cyc);
    end
    ack_now(16'h1234);
    n_tests++;
    if ({instr_valid, imem_req, instr, instr_pc} !== {1'b1, 1'b0, 16'h1234, 16'h0000}) begin
      n_fail++;
      $display("FAIL basic_deliver0: got v=%b req=%b instr=%h pc=%h required 1/0/1234/0000",
               instr_valid, imem_req, instr, instr_pc);
    end
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0001 || cyc != 2) begin
      n_fail++;
      $display("FAIL basic_req1: got ok=%b addr=%h gap=%0d required 1/0001/2", ok, imem_addr, cyc);
    end
    ack_now(16'h5678);
    n_tests++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h5678, 16'h0001}) begin
      n_fail++;
      $display("FAIL basic_deliver1: got v=%b instr=%h pc=%h required 1/5678/0001",
               instr_valid, instr, instr_pc);
    end
    stall = 1'b1;
    tick();
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consumed: got v=%b required 0", instr_valid);
    end
  endtask

  task automatic test_ready_hold;
    bit ok; int cyc; bit sv;
    redirect_now(16'h0003);
    stall = 1'b0;
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0003) begin
      n_fail++;
      $display("FAIL hold_req: got ok=%b addr=%h required 1/0003", ok, imem_addr);
    end
    instr_ready = 1'b0;
    ack_now(16'hA003);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({instr_valid, imem_req, instr, instr_pc} !== {1'b1, 1'b0, 16'hA003, 16'h0003}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%b req=%b instr=%h pc=%h required 1/0/A003/0003",
                 i, instr_valid, imem_req, instr, instr_pc);
      end
      tick();
    end
    instr_ready = 1'b1;
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0004 || cyc != 2) begin
      n_fail++;
      $display("FAIL hold_next: got ok=%b addr=%h gap=%0d required 1/0004/2", ok, imem_addr, cyc);
    end
  endtask

  task automatic test_redirect_deliver;
    bit ok; int cyc; bit sv;
    instr_ready = 1'b0;
    ack_now(16'hA004);
    redirect_now(16'h0040);
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_deliver_squash: got v=%b required 0", instr_valid);
    end
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0040 || cyc > 1) begin
      n_fail++;
      $display("FAIL redir_deliver_next: got ok=%b addr=%h lat=%0d required 1/0040/<=1", ok, imem_addr, cyc);
    end
  endtask

  task automatic test_redirect_drain;
    bit ok; int cyc; bit sv;
    redirect_now(16'h0080);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: got req=%b addr=%h v=%b required 1/0040/0",
                 i, imem_req, imem_addr, instr_valid);
      end
      tick();
    end
    ack_now(16'hDEAD);
    instr_ready = 1'b1;
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_drop: got v=%b req=%b required 0/0", instr_valid, imem_req);
    end
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0080 || sv || instr === 16'hDEAD) begin
      n_fail++;
      $display("FAIL drain_next: got ok=%b addr=%h vpulse=%b instr=%h required 1/0080/0/not DEAD",
               ok, imem_addr, sv, instr);
    end
    ack_now(16'hB080);
    n_tests++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hB080, 16'h0080}) begin
      n_fail++;
      $display("FAIL drain_deliver: got v=%b instr=%h pc=%h required 1/B080/0080", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_redirect_on_ack_and_stall;
    bit ok; int cyc; bit sv;
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0081) begin
      n_fail++;
      $display("FAIL ackredir_req: got ok=%b addr=%h required 1/0081", ok, imem_addr);
    end
    pc_write_enabled = 1'b1; dest_address = 16'h0100;
    imem_ack = 1'b1; imem_rdata = 16'hC0DE;
    tick();
    pc_write_enabled = 1'b0; imem_ack = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ackredir_drop: got v=%b req=%b required 0/0", instr_valid, imem_req);
    end
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0100 || sv || cyc != 1) begin
      n_fail++;
      $display("FAIL ackredir_next: got ok=%b addr=%h vpulse=%b lat=%0d required 1/0100/0/1",
               ok, imem_addr, sv, cyc);
    end
    ack_now(16'hB100);
    stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_idle[%0d]: got req=%b required 0", i, imem_req);
      end
      tick();
    end
    stall = 1'b0;
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0101 || cyc != 1) begin
      n_fail++;
      $display("FAIL stall_release: got ok=%b addr=%h lat=%0d required 1/0101/1", ok, imem_addr, cyc);
    end
  endtask

  task automatic test_wrap;
    bit ok; int cyc; bit sv;
    ack_now(16'h5101);
    stall = 1'b1;
    tick();
    redirect_now(16'hFFFF);
    stall = 1'b0;
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_req: got ok=%b addr=%h required 1/FFFF", ok, imem_addr);
    end
    ack_now(16'hBEEF);
    n_tests++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hBEEF, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL wrap_deliver: got v=%b instr=%h pc=%h required 1/BEEF/FFFF", instr_valid, instr, instr_pc);
    end
    tick();
`ifdef FETCH_WRAP_TRAP_EN
    n_tests++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL wrap_fault: got %b required 1", fault); end
    redirect_now(16'h0010);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (imem_req !== 1'b0 || fault !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got req=%b fault=%b required 0/1", i, imem_req, fault);
      end
      tick();
    end
`else
    wait_req(10, ok, cyc, sv);
    n_tests++;
    if (!ok || imem_addr !== 16'h0000 || cyc != 1) begin
      n_fail++;
      $display("FAIL wrap_next: got ok=%b addr=%h lat=%0d required 1/0000/1", ok, imem_addr, cyc);
    end
`endif
  endtask

  task automatic test_async_reset;
    bit ok; int cyc; bit sv;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    stall = 1'b0;
    wait_req(10, ok, cyc, sv);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || imem_req !== 1'b0 || imem_addr !== RV || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ok=%b req=%b addr=%h v=%b required 1/0/%h/0",
               ok, imem_req, imem_addr, instr_valid, RV);
    end
    tick();
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic [15:0] exp_next, prev_addr;
    bit prev_req, live, exp_v;
    int ack_wait;
    stall = 1'b1; pc_write_enabled = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_next = RV; prev_req = 1'b0; prev_addr = '0; live = 1'b0; ack_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (imem_req && !prev_req) begin
        live = 1'b1;
        n_tests++;
        if (imem_addr !== exp_next || instr_valid) begin
          n_fail++;
          $display("FAIL rnd_req_addr @%0d: got addr=%h v=%b required %h/0", cyc, imem_addr, instr_valid, exp_next);
        end
      end else if (imem_req && prev_req) begin
        n_tests++;
        if (imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL rnd_addr_stable @%0d: got %h required %h", cyc, imem_addr, prev_addr);
        end
      end
      exp_v = (q.size() != 0);
      n_tests++;
      if (instr_valid !== exp_v) begin
        n_fail++;
        $display("FAIL rnd_valid @%0d: got %b required %b", cyc, instr_valid, exp_v);
      end else if (exp_v) begin
        n_tests++;
        if ({instr_pc, instr} !== q[0]) begin
          n_fail++;
          $display("FAIL rnd_instr @%0d: got pc=%h instr=%h required pc=%h instr=%h",
                   cyc, instr_pc, instr, q[0][31:16], q[0][15:0]);
        end
      end
      stall            = ($urandom_range(0, 3) == 0);
      instr_ready      = 1'($urandom_range(0, 1));
      pc_write_enabled = ($urandom_range(0, 9) == 0);
      dest_address     = 16'($urandom_range(0, 16'h7FFF));
      imem_rdata       = 16'($urandom);
      imem_ack         = 1'b0;
      if (imem_req) begin
        if (ack_wait == 0) begin
          imem_ack = 1'b1;
          ack_wait = $urandom_range(0, 3);
        end else begin
          ack_wait--;
        end
      end
      if (pc_write_enabled) begin
        exp_next = dest_address;
        if (q.size() != 0) void'(q.pop_front());
      end else if (instr_valid && instr_ready && q.size() != 0) begin
        void'(q.pop_front());
      end
      if (imem_req && imem_ack) begin
        if (live && !pc_write_enabled) begin
          q.push_back({imem_addr, imem_rdata});
          exp_next = imem_addr + 16'd1;
        end
        live = 1'b0;
      end
      if (pc_write_enabled) live = 1'b0;
      prev_req  = imem_req && !imem_ack;
      prev_addr = imem_addr;
      tick();
    end
    pc_write_enabled = 1'b0;
    imem_ack = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL rnd_fault: got %b required 0", fault); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_hold();
    test_redirect_deliver();
    test_redirect_drain();
    test_redirect_on_ack_and_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
